// File: rtl/game_state_fsm_if.sv
// Game flow bus: frame/key/collision events into the flow controller,
// and the game-state, counters and restart pulses out to the object and
// background modules.
interface game_state_fsm_if;
    logic       startOfFrame;
    logic       spaceKey;
    logic       playerHit;
    logic       levelCleared;
    logic [1:0] gameState;
    logic [2:0] lives;
    logic [2:0] level;
    logic       freezeActive;
    logic       winFlag;
    logic       levelStart;
    logic       gameReset;

    // Flow controller side: consumes events, drives state and pulses.
    modport master (
        input  startOfFrame,
        input  spaceKey,
        input  playerHit,
        input  levelCleared,
        output gameState,
        output lives,
        output level,
        output freezeActive,
        output winFlag,
        output levelStart,
        output gameReset
    );

    // Environment side: produces events, observes state and pulses.
    modport slave (
        output startOfFrame,
        output spaceKey,
        output playerHit,
        output levelCleared,
        input  gameState,
        input  lives,
        input  level,
        input  freezeActive,
        input  winFlag,
        input  levelStart,
        input  gameReset
    );
endinterface

// File: rtl/game_state_fsm.sv
// Bubble Trouble top-level game flow controller: title, play, hit freeze,
// level clear and game over phases, with lives/level counters, a frame
// timer for the timed phases, and one-cycle restart pulses.
module game_state_fsm #(
    parameter int unsigned INIT_LIVES      = 3,
    parameter int unsigned MAX_LEVEL       = 4,
    parameter int unsigned FREEZE_FRAMES   = 60,
    parameter int unsigned CLEAR_FRAMES    = 90,
    parameter int unsigned GAMEOVER_FRAMES = 300
) (
    input  logic             clk,
    input  logic             resetN,
    game_state_fsm_if.master bus
);

    typedef enum logic [2:0] {
        TITLE,
        PLAY,
        HIT_FREEZE,
        LEVEL_CLEAR,
        GAME_OVER
    } flowStateT;

    localparam logic [2:0] LIVES_INIT    = 3'(INIT_LIVES);
    localparam logic [2:0] LEVEL_LAST    = 3'(MAX_LEVEL);
    localparam logic [9:0] FREEZE_LOAD   = 10'(FREEZE_FRAMES);
    localparam logic [9:0] CLEAR_LOAD    = 10'(CLEAR_FRAMES);
    localparam logic [9:0] GAMEOVER_LOAD = 10'(GAMEOVER_FRAMES);

    flowStateT  state;
    flowStateT  stateNext;

    logic       spaceKeyD;
    logic       spacePress;

    logic [2:0] livesReg;
    logic [2:0] livesNext;
    logic [2:0] levelReg;
    logic [2:0] levelNext;
    logic [9:0] timerReg;
    logic [9:0] timerNext;
    logic [9:0] timerDec;
    logic       timerExpire;

    logic       winReg;
    logic       winNext;
    logic [1:0] gameStateReg;
    logic [1:0] gameStateNext;
    logic       freezeReg;
    logic       freezeNext;
    logic       levelStartReg;
    logic       levelStartNext;
    logic       gameResetReg;
    logic       gameResetNext;

    // Rising edge of the space key; the delay register resets high so a
    // key held through reset is not seen as a press.
    assign spacePress = bus.spaceKey & ~spaceKeyD;

    // Frame timer step: saturating decrement, expiry on the frame pulse
    // that takes the count from 1 to 0.
    assign timerDec    = (timerReg != '0) ? (timerReg - 10'd1) : '0;
    assign timerExpire = bus.startOfFrame && (timerReg <= 10'd1);

    // State and counter registers, including every registered output.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= TITLE;
            spaceKeyD     <= 1'b1;
            livesReg      <= LIVES_INIT;
            levelReg      <= 3'd1;
            timerReg      <= '0;
            winReg        <= 1'b0;
            gameStateReg  <= 2'd0;
            freezeReg     <= 1'b0;
            levelStartReg <= 1'b0;
            gameResetReg  <= 1'b0;
        end else begin
            state         <= stateNext;
            spaceKeyD     <= bus.spaceKey;
            livesReg      <= livesNext;
            levelReg      <= levelNext;
            timerReg      <= timerNext;
            winReg        <= winNext;
            gameStateReg  <= gameStateNext;
            freezeReg     <= freezeNext;
            levelStartReg <= levelStartNext;
            gameResetReg  <= gameResetNext;
        end
    end

    // Next-state, counter updates and restart pulses for each phase.
    always_comb begin
        stateNext      = state;
        livesNext      = livesReg;
        levelNext      = levelReg;
        timerNext      = timerReg;
        winNext        = winReg;
        levelStartNext = 1'b0;
        gameResetNext  = 1'b0;

        case (state)
            TITLE: begin
                if (spacePress) begin
                    stateNext      = PLAY;
                    livesNext      = LIVES_INIT;
                    levelNext      = 3'd1;
                    winNext        = 1'b0;
                    timerNext      = '0;
                    gameResetNext  = 1'b1;
                    levelStartNext = 1'b1;
                end
            end

            PLAY: begin
                // A hit takes priority; a simultaneous clear is dropped.
                if (bus.playerHit) begin
                    livesNext = (livesReg != '0) ? (livesReg - 3'd1) : '0;
                    if (livesReg <= 3'd1) begin
                        stateNext = GAME_OVER;
                        winNext   = 1'b0;
                        timerNext = GAMEOVER_LOAD;
                    end else begin
                        stateNext = HIT_FREEZE;
                        timerNext = FREEZE_LOAD;
                    end
                end else if (bus.levelCleared) begin
                    if (levelReg >= LEVEL_LAST) begin
                        stateNext = GAME_OVER;
                        winNext   = 1'b1;
                        timerNext = GAMEOVER_LOAD;
                    end else begin
                        stateNext = LEVEL_CLEAR;
                        timerNext = CLEAR_LOAD;
                    end
                end
            end

            HIT_FREEZE: begin
                if (bus.startOfFrame) begin
                    timerNext = timerDec;
                    if (timerExpire) begin
                        stateNext      = PLAY;
                        levelStartNext = 1'b1;
                    end
                end
            end

            LEVEL_CLEAR: begin
                if (bus.startOfFrame) begin
                    timerNext = timerDec;
                    if (timerExpire) begin
                        stateNext      = PLAY;
                        levelStartNext = 1'b1;
                        levelNext      = (levelReg < LEVEL_LAST) ?
                                         (levelReg + 3'd1) : levelReg;
                    end
                end
            end

            GAME_OVER: begin
                if (spacePress) begin
                    stateNext = TITLE;
                    winNext   = 1'b0;
                    timerNext = '0;
                end else if (bus.startOfFrame) begin
                    timerNext = timerDec;
                    if (timerExpire) begin
                        stateNext = TITLE;
                        winNext   = 1'b0;
                    end
                end
            end

            default: begin
                stateNext = TITLE;
                timerNext = '0;
                winNext   = 1'b0;
            end
        endcase
    end

    // Output encodings derived from the upcoming state so they register
    // in step with it.
    always_comb begin
        gameStateNext = 2'd1;
        freezeNext    = 1'b0;
        case (stateNext)
            TITLE:       gameStateNext = 2'd0;
            GAME_OVER:   gameStateNext = 2'd2;
            HIT_FREEZE:  freezeNext    = 1'b1;
            LEVEL_CLEAR: freezeNext    = 1'b1;
            default:     gameStateNext = 2'd1;
        endcase
    end

    assign bus.gameState    = gameStateReg;
    assign bus.lives        = livesReg;
    assign bus.level        = levelReg;
    assign bus.freezeActive = freezeReg;
    assign bus.winFlag      = winReg;
    assign bus.levelStart   = levelStartReg;
    assign bus.gameReset    = gameResetReg;

endmodule

// File: tb/tb_game_state_fsm.sv
// Self-checking bench for game_state_fsm: expected output snapshots are
// queued when stimulus is applied and popped when the DUT has responded.
module tb_game_state_fsm;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    typedef struct {
        string      name;
        logic [11:0] v;
    } expT;

    expT sbq[$];

    game_state_fsm_if gameBus();

    game_state_fsm #(
        .INIT_LIVES      (3),
        .MAX_LEVEL       (4),
        .FREEZE_FRAMES   (60),
        .CLEAR_FRAMES    (90),
        .GAMEOVER_FRAMES (300)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (gameBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Snapshot layout: gameState, lives, level, freeze, win, levelStart, gameReset.
    function automatic logic [11:0] mk(input logic [1:0] gs, input logic [2:0] lv,
                                       input logic [2:0] lev, input logic fr,
                                       input logic win, input logic ls, input logic gr);
        return {gs, lv, lev, fr, win, ls, gr};
    endfunction

    function automatic logic [11:0] obs();
        return {gameBus.gameState, gameBus.lives, gameBus.level, gameBus.freezeActive,
                gameBus.winFlag, gameBus.levelStart, gameBus.gameReset};
    endfunction

    task automatic push(input string name, input logic [11:0] v);
        expT e;
        e.name = name;
        e.v    = v;
        sbq.push_back(e);
    endtask

    // One clock with the given inputs; sampling point is 1 ns after the edge.
    task automatic step(input logic sof, input logic sp, input logic hit, input logic clr);
        gameBus.startOfFrame = sof;
        gameBus.spaceKey     = sp;
        gameBus.playerHit    = hit;
        gameBus.levelCleared = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        expT e;
        resetN = 1'b0;
        gameBus.startOfFrame = 1'b0;
        gameBus.spaceKey     = 1'b1;
        gameBus.playerHit    = 1'b0;
        gameBus.levelCleared = 1'b0;
        push("reset_state", mk(2'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        resetN = 1'b1;
        push("key_held_thru_reset", mk(2'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_start();
        expT e;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        push("start_press", mk(2'd1, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("start_pulses_end", mk(2'd1, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_hit_freeze();
        expT e;
        push("hit_enter_freeze", mk(2'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("hit_during_freeze", mk(2'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        // First frame carries a hit too; the frame counts, the hit does not.
        push("hit_with_frame", mk(2'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        frames(58);
        push("freeze_frame59", mk(2'd1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("freeze_exit", mk(2'd1, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("freeze_exit_pulse_end", mk(2'd1, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_lives_to_zero();
        expT e;
        push("second_hit", mk(2'd1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        frames(59);
        push("second_freeze_exit", mk(2'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        push("last_life_hit", mk(2'd2, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_gameover_timeout();
        expT e;
        frames(299);
        push("gameover_frame299", mk(2'd2, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("gameover_timeout", mk(2'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_level_clear();
        expT e;
        push("restart_press", mk(2'd1, 3'd3, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int unsigned l = 1; l <= 3; l++) begin
            push($sformatf("clear_enter_l%0d", l), mk(2'd1, 3'd3, 3'(l), 1'b1, 1'b0, 1'b0, 1'b0));
            step(1'b0, 1'b0, 1'b0, 1'b1);
            e = sbq.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
            end
            frames(89);
            push($sformatf("clear_exit_l%0d", l), mk(2'd1, 3'd3, 3'(l + 1), 1'b0, 1'b0, 1'b1, 1'b0));
            step(1'b1, 1'b0, 1'b0, 1'b0);
            e = sbq.pop_front();
            checks++;
            if (obs() !== e.v) begin
                errors++;
                $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
            end
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        push("clear_max_level_win", mk(2'd2, 3'd3, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    task automatic test_gameover_press();
        expT e;
        frames(5);
        push("gameover_press", mk(2'd0, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous();
        expT e;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        frames(60);
        push("pre_simul_state", mk(2'd1, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("hit_and_clear", mk(2'd1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b1, 1'b1);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        push("clear_during_freeze", mk(2'd1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        frames(59);
        push("simul_freeze_exit", mk(2'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        push("press_in_play", mk(2'd1, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_freeze();
        expT e;
        push("enter_clear_for_reset", mk(2'd1, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        frames(10);
        push("async_reset_mid_freeze", mk(2'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        resetN = 1'b0;
        #1;
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
        @(negedge clk);
        resetN = 1'b1;
        push("after_reset_release", mk(2'd0, 3'd3, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        e = sbq.pop_front();
        checks++;
        if (obs() !== e.v) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", e.name, obs(), e.v);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_start();
        test_hit_freeze();
        test_lives_to_zero();
        test_gameover_timeout();
        test_level_clear();
        test_gameover_press();
        test_simultaneous();
        test_reset_mid_freeze();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
